// File: rtl/ssram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ssram_port_arbiter
//
// Shares one SSRAM-style target request/response port between two masters:
// M0 (instruction fetch) and M1 (load/store). One request is granted per
// cycle, either round-robin or with M1 winning every tie. The owner of each
// accepted read is pushed into an in-order tag FIFO so that read responses,
// which the target returns in issue order, are routed back to the master
// that issued them. Writes never produce a response and bypass the FIFO.
//
// Ports:
//   clk_i, resetb_i, clk_en_i        clock, async active-low reset, enable
//   mX_req*                          master X request channel (valid/ready,
//                                    write flag, address, write data)
//   mX_rsp*                          master X response channel
//   treq* / trsp*                    shared target request/response channel
//   err_o                            sticky: response arrived with no
//                                    outstanding read (cleared by reset only)
// ---------------------------------------------------------------------------
module ssram_port_arbiter #(
  parameter int C_MAX_OUTSTANDING = 4,
  parameter bit C_FIXED_PRIORITY  = 1'b0
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  // master 0
  output logic        m0_reqready_o,
  input  logic        m0_reqvalid_i,
  input  logic        m0_reqdvalid_i,
  input  logic [31:0] m0_reqaddr_i,
  input  logic [31:0] m0_reqdata_i,
  input  logic        m0_rspready_i,
  output logic        m0_rspvalid_o,
  output logic [31:0] m0_rspdata_o,
  // master 1
  output logic        m1_reqready_o,
  input  logic        m1_reqvalid_i,
  input  logic        m1_reqdvalid_i,
  input  logic [31:0] m1_reqaddr_i,
  input  logic [31:0] m1_reqdata_i,
  input  logic        m1_rspready_i,
  output logic        m1_rspvalid_o,
  output logic [31:0] m1_rspdata_o,
  // target
  input  logic        treqready_i,
  output logic        treqvalid_o,
  output logic        treqdvalid_o,
  output logic [31:0] treqaddr_o,
  output logic [31:0] treqdata_o,
  output logic        trspready_o,
  input  logic        trspvalid_i,
  input  logic [31:0] trspdata_i,
  output logic        err_o
);

  localparam int AW = (C_MAX_OUTSTANDING > 1) ? $clog2(C_MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(C_MAX_OUTSTANDING + 1);

  // Per-master views so the per-master logic can be generated uniformly
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [31:0] req_addr [2];
  logic [31:0] req_data [2];
  logic [1:0]  rsp_ready;
  logic [1:0]  eligible;
  logic [1:0]  rsp_valid;

  assign req_valid   = {m1_reqvalid_i, m0_reqvalid_i};
  assign req_write   = {m1_reqdvalid_i, m0_reqdvalid_i};
  assign req_addr[0] = m0_reqaddr_i;
  assign req_addr[1] = m1_reqaddr_i;
  assign req_data[0] = m0_reqdata_i;
  assign req_data[1] = m1_reqdata_i;
  assign rsp_ready   = {m1_rspready_i, m0_rspready_i};

  // State
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          last_grant_reg, last_grant_next;
  logic          err_reg, err_next;
  logic          tag_mem [C_MAX_OUTSTANDING];

  logic fifo_empty;
  logic fifo_full;
  logic head_id;
  logic grant_valid;
  logic grant_id;
  logic accept;
  logic push;
  logic pop;
  logic stray;

  assign fifo_empty = (count_reg == '0);
  // Uses the registered count: a pop in the same cycle does not free a slot
  // for a read until the next cycle.
  assign fifo_full  = (count_reg == CW'(C_MAX_OUTSTANDING));
  assign head_id    = tag_mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign eligible[gi]  = req_valid[gi] & (req_write[gi] | ~fifo_full);
      assign rsp_valid[gi] = trspvalid_i & ~fifo_empty & (head_id == 1'(gi));
    end
  endgenerate

  // Grant selection
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    case (eligible)
      2'b01: begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_id    = C_FIXED_PRIORITY ? 1'b1 : ~last_grant_reg;
      end
      default: begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
      end
    endcase
  end

  // Request mux: all-zero when idle
  assign treqvalid_o   = grant_valid;
  assign treqdvalid_o  = grant_valid & req_write[grant_id];
  assign treqaddr_o    = grant_valid ? req_addr[grant_id] : 32'd0;
  assign treqdata_o    = grant_valid ? req_data[grant_id] : 32'd0;
  assign m0_reqready_o = grant_valid & (grant_id == 1'b0) & treqready_i;
  assign m1_reqready_o = grant_valid & (grant_id == 1'b1) & treqready_i;

  // Response routing; with nothing outstanding the target is drained
  assign trspready_o   = fifo_empty | rsp_ready[head_id];
  assign m0_rspvalid_o = rsp_valid[0];
  assign m1_rspvalid_o = rsp_valid[1];
  assign m0_rspdata_o  = trspdata_i;
  assign m1_rspdata_o  = trspdata_i;
  assign err_o         = err_reg;

  assign accept = grant_valid & treqready_i & clk_en_i;
  assign push   = accept & ~req_write[grant_id];
  assign pop    = trspvalid_i & trspready_o & ~fifo_empty & clk_en_i;
  assign stray  = trspvalid_i & fifo_empty & clk_en_i;

  always_comb begin
    count_next      = count_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    last_grant_next = last_grant_reg;
    err_next        = err_reg;
    if (accept) begin
      last_grant_next = grant_id;
    end
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
    if (stray) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      last_grant_reg <= 1'b1;  // M0 wins the first tie
      err_reg        <= 1'b0;
    end else begin
      count_reg      <= count_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      last_grant_reg <= last_grant_next;
      err_reg        <= err_next;
    end
  end

  // Tag storage needs no reset: the head is only looked at when non-empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem[wr_ptr_reg] <= grant_id;
    end
  end

endmodule

// File: tb/tb_ssram_port_arbiter.sv
module tb_ssram_port_arbiter;

  logic        clk_i = 1'b0;
  logic        resetb_i;
  logic        clk_en_i;
  logic        m0_reqvalid_i, m0_reqdvalid_i, m0_rspready_i;
  logic [31:0] m0_reqaddr_i, m0_reqdata_i;
  logic        m1_reqvalid_i, m1_reqdvalid_i, m1_rspready_i;
  logic [31:0] m1_reqaddr_i, m1_reqdata_i;
  logic        treqready_i, trspvalid_i;
  logic [31:0] trspdata_i;

  // round-robin instance outputs
  logic        m0_reqready_o, m0_rspvalid_o, m1_reqready_o, m1_rspvalid_o;
  logic [31:0] m0_rspdata_o, m1_rspdata_o;
  logic        treqvalid_o, treqdvalid_o, trspready_o, err_o;
  logic [31:0] treqaddr_o, treqdata_o;

  // fixed-priority instance outputs
  logic        fp_m0_reqready, fp_m0_rspvalid, fp_m1_reqready, fp_m1_rspvalid;
  logic [31:0] fp_m0_rspdata, fp_m1_rspdata;
  logic        fp_treqvalid, fp_treqdvalid, fp_trspready, fp_err;
  logic [31:0] fp_treqaddr, fp_treqdata;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  ssram_port_arbiter #(.C_MAX_OUTSTANDING(4), .C_FIXED_PRIORITY(1'b0)) dut (
    .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
    .m0_reqready_o(m0_reqready_o), .m0_reqvalid_i(m0_reqvalid_i),
    .m0_reqdvalid_i(m0_reqdvalid_i), .m0_reqaddr_i(m0_reqaddr_i),
    .m0_reqdata_i(m0_reqdata_i), .m0_rspready_i(m0_rspready_i),
    .m0_rspvalid_o(m0_rspvalid_o), .m0_rspdata_o(m0_rspdata_o),
    .m1_reqready_o(m1_reqready_o), .m1_reqvalid_i(m1_reqvalid_i),
    .m1_reqdvalid_i(m1_reqdvalid_i), .m1_reqaddr_i(m1_reqaddr_i),
    .m1_reqdata_i(m1_reqdata_i), .m1_rspready_i(m1_rspready_i),
    .m1_rspvalid_o(m1_rspvalid_o), .m1_rspdata_o(m1_rspdata_o),
    .treqready_i(treqready_i), .treqvalid_o(treqvalid_o),
    .treqdvalid_o(treqdvalid_o), .treqaddr_o(treqaddr_o),
    .treqdata_o(treqdata_o), .trspready_o(trspready_o),
    .trspvalid_i(trspvalid_i), .trspdata_i(trspdata_i), .err_o(err_o)
  );

  ssram_port_arbiter #(.C_MAX_OUTSTANDING(4), .C_FIXED_PRIORITY(1'b1)) dut_fp (
    .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
    .m0_reqready_o(fp_m0_reqready), .m0_reqvalid_i(m0_reqvalid_i),
    .m0_reqdvalid_i(m0_reqdvalid_i), .m0_reqaddr_i(m0_reqaddr_i),
    .m0_reqdata_i(m0_reqdata_i), .m0_rspready_i(m0_rspready_i),
    .m0_rspvalid_o(fp_m0_rspvalid), .m0_rspdata_o(fp_m0_rspdata),
    .m1_reqready_o(fp_m1_reqready), .m1_reqvalid_i(m1_reqvalid_i),
    .m1_reqdvalid_i(m1_reqdvalid_i), .m1_reqaddr_i(m1_reqaddr_i),
    .m1_reqdata_i(m1_reqdata_i), .m1_rspready_i(m1_rspready_i),
    .m1_rspvalid_o(fp_m1_rspvalid), .m1_rspdata_o(fp_m1_rspdata),
    .treqready_i(treqready_i), .treqvalid_o(fp_treqvalid),
    .treqdvalid_o(fp_treqdvalid), .treqaddr_o(fp_treqaddr),
    .treqdata_o(fp_treqdata), .trspready_o(fp_trspready),
    .trspvalid_i(trspvalid_i), .trspdata_i(trspdata_i), .err_o(fp_err)
  );

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    clk_en_i       = 1'b1;
    m0_reqvalid_i  = 1'b0; m0_reqdvalid_i = 1'b0; m0_rspready_i = 1'b1;
    m0_reqaddr_i   = 32'd0; m0_reqdata_i  = 32'd0;
    m1_reqvalid_i  = 1'b0; m1_reqdvalid_i = 1'b0; m1_rspready_i = 1'b1;
    m1_reqaddr_i   = 32'd0; m1_reqdata_i  = 32'd0;
    treqready_i    = 1'b1;
    trspvalid_i    = 1'b0;
    trspdata_i     = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetb_i = 1'b0;
    tick();
    tick();
    resetb_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (treqvalid_o !== 1'b0 || m0_rspvalid_o !== 1'b0 || m1_rspvalid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: treqvalid=%b rsp0=%b rsp1=%b required 0 0 0",
               treqvalid_o, m0_rspvalid_o, m1_rspvalid_o);
    end
    tests++;
    if (err_o !== 1'b0 || trspready_o !== 1'b1 || treqaddr_o !== 32'd0) begin
      fails++;
      $display("FAIL reset_misc: err=%b trspready=%b treqaddr=%h required 0 1 0",
               err_o, trspready_o, treqaddr_o);
    end
    tests++;
    if (dut.count_reg !== 3'd0) begin
      fails++;
      $display("FAIL reset_count: count=%0d required 0", dut.count_reg);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    do_reset();
    m0_reqvalid_i = 1'b1; m0_reqaddr_i = 32'h100;
    #1;
    tests++;
    if (treqvalid_o !== 1'b1 || treqaddr_o !== 32'h100 || treqdvalid_o !== 1'b0 ||
        m0_reqready_o !== 1'b1 || m1_reqready_o !== 1'b0) begin
      fails++;
      $display("FAIL single_req: tv=%b ta=%h tw=%b rdy0=%b rdy1=%b required 1 00000100 0 1 0",
               treqvalid_o, treqaddr_o, treqdvalid_o, m0_reqready_o, m1_reqready_o);
    end
    tick();
    m0_reqvalid_i = 1'b0;
    trspvalid_i = 1'b1; trspdata_i = 32'h11223344;
    #1;
    tests++;
    if (m0_rspvalid_o !== 1'b1 || m0_rspdata_o !== 32'h11223344 ||
        m1_rspvalid_o !== 1'b0 || trspready_o !== 1'b1) begin
      fails++;
      $display("FAIL single_rsp: v0=%b d0=%h v1=%b trdy=%b required 1 11223344 0 1",
               m0_rspvalid_o, m0_rspdata_o, m1_rspvalid_o, trspready_o);
    end
    tests++;
    if (dut.count_reg !== 3'd1) begin
      fails++;
      $display("FAIL single_count_inflight: count=%0d required 1", dut.count_reg);
    end
    tick();
    trspvalid_i = 1'b0;
    tests++;
    if (dut.count_reg !== 3'd0 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL single_count_done: count=%0d err=%b required 0 0", dut.count_reg, err_o);
    end
    $display("[TB] single read 0x100 -> 0x11223344");
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_reqvalid_i = 1'b1; m0_reqaddr_i = 32'h200;
    m1_reqvalid_i = 1'b1; m1_reqaddr_i = 32'h300;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (m0_reqready_o !== (i % 2 == 0) || m1_reqready_o !== (i % 2 == 1) ||
          treqaddr_o !== ((i % 2 == 0) ? 32'h200 : 32'h300)) begin
        fails++;
        $display("FAIL rr_grant[%0d]: rdy0=%b rdy1=%b addr=%h required grant M%0d",
                 i, m0_reqready_o, m1_reqready_o, treqaddr_o, i % 2);
      end
      $display("[TB] rr cycle %0d addr=%h", i, treqaddr_o);
      tick();
    end
    m0_reqvalid_i = 1'b0; m1_reqvalid_i = 1'b0;
    tests++;
    if (dut.count_reg !== 3'd4) begin
      fails++;
      $display("FAIL rr_count: count=%0d required 4", dut.count_reg);
    end
    for (int i = 0; i < 4; i++) begin
      trspvalid_i = 1'b1; trspdata_i = 32'hA0 + 32'(i);
      #1;
      tests++;
      if (m0_rspvalid_o !== (i % 2 == 0) || m1_rspvalid_o !== (i % 2 == 1) ||
          m0_rspdata_o !== 32'hA0 + 32'(i)) begin
        fails++;
        $display("FAIL rr_rsp[%0d]: v0=%b v1=%b data=%h required M%0d data %h",
                 i, m0_rspvalid_o, m1_rspvalid_o, m0_rspdata_o, i % 2, 32'hA0 + 32'(i));
      end
      tick();
    end
    trspvalid_i = 1'b0;
    tests++;
    if (dut.count_reg !== 3'd0) begin
      fails++;
      $display("FAIL rr_drain: count=%0d required 0", dut.count_reg);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    m0_reqvalid_i = 1'b1; m0_reqaddr_i = 32'h200;
    m1_reqvalid_i = 1'b1; m1_reqaddr_i = 32'h300;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (fp_m1_reqready !== 1'b1 || fp_m0_reqready !== 1'b0 || fp_treqaddr !== 32'h300) begin
        fails++;
        $display("FAIL fp_grant[%0d]: rdy0=%b rdy1=%b addr=%h required 0 1 00000300",
                 i, fp_m0_reqready, fp_m1_reqready, fp_treqaddr);
      end
      $display("[TB] fixed-priority cycle %0d addr=%h", i, fp_treqaddr);
      tick();
    end
    m0_reqvalid_i = 1'b0; m1_reqvalid_i = 1'b0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    m0_reqvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_reqaddr_i = 32'h400 + 32'(4 * i);
      #1;
      tests++;
      if (m0_reqready_o !== 1'b1) begin
        fails++;
        $display("FAIL full_fill[%0d]: rdy0=%b required 1", i, m0_reqready_o);
      end
      tick();
    end
    m0_reqaddr_i = 32'h410;
    #1;
    tests++;
    if (treqvalid_o !== 1'b0 || m0_reqready_o !== 1'b0) begin
      fails++;
      $display("FAIL full_stall: tv=%b rdy0=%b required 0 0", treqvalid_o, m0_reqready_o);
    end
    m1_reqvalid_i = 1'b1; m1_reqdvalid_i = 1'b1;
    m1_reqaddr_i = 32'h80000000; m1_reqdata_i = 32'hCAFEF00D;
    #1;
    tests++;
    if (m0_reqready_o !== 1'b0 || m1_reqready_o !== 1'b1 || treqdvalid_o !== 1'b1 ||
        treqaddr_o !== 32'h80000000 || treqdata_o !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL full_write: rdy0=%b rdy1=%b tw=%b ta=%h td=%h required 0 1 1 80000000 cafef00d",
               m0_reqready_o, m1_reqready_o, treqdvalid_o, treqaddr_o, treqdata_o);
    end
    tick();
    m1_reqvalid_i = 1'b0; m1_reqdvalid_i = 1'b0;
    tests++;
    if (dut.count_reg !== 3'd4) begin
      fails++;
      $display("FAIL full_write_count: count=%0d required 4", dut.count_reg);
    end
    trspvalid_i = 1'b1; trspdata_i = 32'h55;
    #1;
    tests++;
    if (m0_reqready_o !== 1'b0 || m0_rspvalid_o !== 1'b1) begin
      fails++;
      $display("FAIL full_pop_cycle: rdy0=%b rsp0=%b required 0 1", m0_reqready_o, m0_rspvalid_o);
    end
    tick();
    trspvalid_i = 1'b0;
    #1;
    tests++;
    if (m0_reqready_o !== 1'b1 || treqaddr_o !== 32'h410) begin
      fails++;
      $display("FAIL full_unblock: rdy0=%b addr=%h required 1 00000410", m0_reqready_o, treqaddr_o);
    end
    tick();
    m0_reqvalid_i = 1'b0;
    tests++;
    if (dut.count_reg !== 3'd4) begin
      fails++;
      $display("FAIL full_refill: count=%0d required 4", dut.count_reg);
    end
    $display("[TB] fifo full scenario done");
  endtask

  task automatic test_stray();
    do_reset();
    trspvalid_i = 1'b1; trspdata_i = 32'hDEAD;
    #1;
    tests++;
    if (trspready_o !== 1'b1 || m0_rspvalid_o !== 1'b0 || m1_rspvalid_o !== 1'b0 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL stray_cycle: trdy=%b v0=%b v1=%b err=%b required 1 0 0 0",
               trspready_o, m0_rspvalid_o, m1_rspvalid_o, err_o);
    end
    tick();
    trspvalid_i = 1'b0;
    tick();
    tick();
    tests++;
    if (err_o !== 1'b1 || dut.count_reg !== 3'd0) begin
      fails++;
      $display("FAIL stray_sticky: err=%b count=%0d required 1 0", err_o, dut.count_reg);
    end
    resetb_i = 1'b0;
    #1;
    tests++;
    if (err_o !== 1'b0) begin
      fails++;
      $display("FAIL stray_clear: err=%b required 0", err_o);
    end
    tick();
    resetb_i = 1'b1;
    $display("[TB] stray response checked");
  endtask

  task automatic test_reset_enable();
    do_reset();
    m0_reqvalid_i = 1'b1; m0_reqaddr_i = 32'h600;
    tick();
    tick();
    m0_reqvalid_i = 1'b0;
    tests++;
    if (dut.count_reg !== 3'd2) begin
      fails++;
      $display("FAIL rst_inflight: count=%0d required 2", dut.count_reg);
    end
    #1;
    resetb_i = 1'b0;
    #1;
    tests++;
    if (dut.count_reg !== 3'd0 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: count=%0d err=%b required 0 0", dut.count_reg, err_o);
    end
    tick();
    resetb_i = 1'b1;
    // a late response for a pre-reset read is a stray
    trspvalid_i = 1'b1;
    #1;
    tests++;
    if (m0_rspvalid_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_late_rsp: rsp0=%b required 0", m0_rspvalid_o);
    end
    tick();
    trspvalid_i = 1'b0;
    tests++;
    if (err_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_late_err: err=%b required 1", err_o);
    end
    clk_en_i = 1'b0;
    m0_reqvalid_i = 1'b1;
    #1;
    tests++;
    if (treqvalid_o !== 1'b1 || m0_reqready_o !== 1'b1) begin
      fails++;
      $display("FAIL en_comb: tv=%b rdy0=%b required 1 1", treqvalid_o, m0_reqready_o);
    end
    tick();
    tick();
    tests++;
    if (dut.count_reg !== 3'd0) begin
      fails++;
      $display("FAIL en_nopush: count=%0d required 0", dut.count_reg);
    end
    // last_grant must still be M1, so M0 wins this tie
    clk_en_i = 1'b1;
    m1_reqvalid_i = 1'b1; m1_reqaddr_i = 32'h700;
    #1;
    tests++;
    if (m0_reqready_o !== 1'b1 || m1_reqready_o !== 1'b0) begin
      fails++;
      $display("FAIL en_lastgrant: rdy0=%b rdy1=%b required 1 0", m0_reqready_o, m1_reqready_o);
    end
    tick();
    m0_reqvalid_i = 1'b0; m1_reqvalid_i = 1'b0;
    tests++;
    if (dut.count_reg !== 3'd1) begin
      fails++;
      $display("FAIL en_resume: count=%0d required 1", dut.count_reg);
    end
    $display("[TB] reset and enable checked");
  endtask

  initial begin
    resetb_i = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_fifo_full();
    test_stray();
    test_reset_enable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssram_port_arbiter.md
# ssram_port_arbiter

Two-master arbiter that shares the single SSRAM-style target request/response port between the instruction-fetch master (M0) and the load/store master (M1). It selects one request per cycle with round-robin or fixed priority and records the owner of every accepted read in an in-order tag FIFO. Read responses are returned to the master that issued them, in issue order. It sits between the core's two bus masters and the memory/virtual-UART target.

## Interface
Parameters:
- C_MAX_OUTSTANDING, 4: read-tag FIFO depth (power of 2, 2..16); maximum reads in flight.
- C_FIXED_PRIORITY, 0: 0 = round-robin; 1 = M1 always wins ties.

Ports (x = 0, 1):
- clk_i  in  1  clock; all state updates on the rising edge.
- resetb_i  in  1  reset, asynchronous and active-low.
- clk_en_i  in  1  clock enable; no state update when low.
- mx_reqready_o  out  1  request accepted this cycle from master x.
- mx_reqvalid_i  in  1  master x request valid.
- mx_reqdvalid_i  in  1  1 = write (carries data), 0 = read.
- mx_reqaddr_i  in  32  byte address.
- mx_reqdata_i  in  32  write data.
- mx_rspready_i  in  1  master x can take a response.
- mx_rspvalid_o  out  1  response valid for master x.
- mx_rspdata_o  out  32  response data; irspdata_i broadcast to both masters.
- treqready_i  in  1  target accepts request.
- treqvalid_o / treqdvalid_o  out  1  muxed request valid / write flag.
- treqaddr_o / treqdata_o  out  32  muxed address / data; 0 when idle.
- trspready_o  out  1  response ready toward target.
- trspvalid_i  in  1  target response valid.
- trspdata_i  in  32  target response data.
- err_o  out  1  sticky: response arrived with no outstanding read.

## Operation
- Eligibility: a master is eligible when its reqvalid is high, and either the request is a write or count < C_MAX_OUTSTANDING. Count is the registered value; a same-cycle pop does not unblock a read.
- Grant (combinational): with one eligible master, that master wins. With both eligible and round-robin, the master not in last_grant wins. With both eligible and C_FIXED_PRIORITY = 1, M1 wins.
- The granted master's fields drive the t-request outputs; treqvalid_o = 1 when a grant exists.
- mx_reqready_o = (grant == x) & treqready_i.
- Accept = treqvalid_o & treqready_i & clk_en_i.
- On accept: last_grant <= granted ID. If the request is a read, push the ID into the tag FIFO.
- Response routing:
  - head = FIFO head ID.
  - mx_rspvalid_o = trspvalid_i & !empty & (head == x).
  - trspready_o = mhead_rspready_i when the FIFO is non-empty; 1 when empty (drain).
- Pop on trspvalid_i & trspready_o & !empty & clk_en_i.
- Empty-FIFO response: the response is dropped, no mx_rspvalid_o is asserted, and err_o <= 1. err_o clears only on reset.
- Count: +1 on push, -1 on pop, unchanged when both happen in the same cycle. Pointers are log2(C_MAX_OUTSTANDING) bits and wrap modulo depth.
- Writes never enter the FIFO and never produce a response.

## Timing
- Reset values:
  - last_grant = M1, so M0 wins the first tie.
  - count = 0, FIFO pointers = 0, err_o = 0.
  - All outputs follow combinationally from the reset state: treqvalid_o = 0 when no request is pending, all rspvalid = 0.
- Request path: zero latency (combinational mux). Grant and ready are stable in the cycle they are sampled.
- Response path: zero added latency. The target's response is routed in the same cycle it arrives.
- Reset asserted mid-operation: FIFO, count and err_o are cleared immediately. Responses arriving afterwards for pre-reset reads set err_o.
- clk_en_i = 0: pointers, count, last_grant and err_o hold. The combinational outputs still reflect the inputs.
- Full FIFO: reads from both masters are stalled and writes still pass. If one master is read-blocked and the other has a write, the write wins.

## Test plan
- Single master: M0 reads 0x100 and the target returns 0x11223344 the next cycle → m0_rspvalid_o = 1 with 0x11223344, m1_rspvalid_o = 0, count returns to 0.
- Contention, round-robin: M0 and M1 both hold reads for 4 cycles → grants are M0, M1, M0, M1. Responses reach the issuers in that order.
- Fixed priority (C_FIXED_PRIORITY = 1): both valid for 3 cycles → M1 granted every cycle and m0_reqready_o stays 0.
- FIFO full: target withholds responses and M0 issues 4 reads → the 5th read is stalled (reqready = 0) while an M1 write to 0x80000000 is accepted. After one response, the 5th read is accepted the following cycle.
- Stray response: trspvalid_i = 1 with an empty FIFO → trspready_o = 1, no rspvalid to either master, err_o goes to 1 and holds until resetb_i = 0.
- Reset and enable: pull resetb_i low with 2 reads in flight → count = 0 immediately. Then hold clk_en_i = 0 with a read pending → no push and no last_grant change.
